// File: rtl/miriscv_mem_arb_pkg.sv
// Shared types for the MIRISCV instruction/data memory arbiter.
//   arb_state_e  : arbiter FSM states
//   owner_e      : which requester owns the transaction in flight
//   STARVE_CNT_W : width of the data-over-instruction starvation counter
package miriscv_mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_e;

  typedef enum logic {OWN_INSTR, OWN_DATA} owner_e;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/miriscv_arb_watchdog.sv
// Response watchdog for the memory arbiter.
//   clk    : clock
//   arstn  : synchronous active-low reset
//   clr    : zero the counter (asserted the cycle before the wait phase starts)
//   en     : count while waiting for a memory response
//   expire : high while enabled and the count has reached TIMEOUT_CYC-1
module miriscv_arb_watchdog #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic arstn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!arstn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire = en && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// Single-port memory arbiter between the MIRISCV fetch and load/store ports.
// One transaction in flight; data has priority over fetch unless the fetch
// has been passed over STARVE_LIMIT times in a row. All outputs registered.
//   clk_i, arstn_i           : clock, synchronous active-low reset
//   instr_req_i/addr_i       : fetch request (held until instr_rvalid_o)
//   instr_rvalid_o/rdata_o   : fetch response, 1-cycle pulse
//   data_req_i/we/be/addr/wdata : load/store request (held until data_rvalid_o)
//   data_rvalid_o/rdata_o    : load/store response, 1-cycle pulse
//   mem_req_o/we/be/addr/wdata : memory request, mem_req_o is a 1-cycle pulse
//   mem_rvalid_i/rdata_i     : memory response
//   timeout_o                : sticky flag, memory failed to answer in time
//   busy_o                   : transaction in flight
module miriscv_mem_arbiter
  import miriscv_mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYC  = 256
) (
  input  logic                clk_i,
  input  logic                arstn_i,
  input  logic                instr_req_i,
  input  logic [ADDR_W-1:0]   instr_addr_i,
  output logic                instr_rvalid_o,
  output logic [DATA_W-1:0]   instr_rdata_o,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_be_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic                data_rvalid_o,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                timeout_o,
  output logic                busy_o
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

  arb_state_e              state_q, state_d;
  owner_e                  owner_q, owner_d;
  logic [STARVE_CNT_W-1:0] starve_q, starve_d;

  logic              mem_req_d, mem_we_d;
  logic [BE_W-1:0]   mem_be_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              instr_rvalid_d, data_rvalid_d;
  logic [DATA_W-1:0] instr_rdata_d, data_rdata_d;
  logic              timeout_d, busy_d;
  logic              grant_instr;
  logic              wd_expire;

  function automatic logic [STARVE_CNT_W-1:0] starve_inc(input logic [STARVE_CNT_W-1:0] cnt);
    return (cnt >= STARVE_MAX) ? STARVE_MAX : cnt + STARVE_CNT_W'(1);
  endfunction

  miriscv_arb_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk   (clk_i),
    .arstn (arstn_i),
    .clr   (state_q == ISSUE),
    .en    (state_q == WAIT),
    .expire(wd_expire)
  );

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    starve_d       = starve_q;
    mem_req_d      = 1'b0;
    mem_we_d       = mem_we_o;
    mem_be_d       = mem_be_o;
    mem_addr_d     = mem_addr_o;
    mem_wdata_d    = mem_wdata_o;
    instr_rvalid_d = 1'b0;
    data_rvalid_d  = 1'b0;
    instr_rdata_d  = instr_rdata_o;
    data_rdata_d   = data_rdata_o;
    timeout_d      = timeout_o;
    grant_instr    = instr_req_i && (!data_req_i || (starve_q == STARVE_MAX));

    case (state_q)
      IDLE: begin
        // While a response is being returned the requester still holds its
        // req; skip arbitration for that cycle so a stale req is not re-granted.
        if (!instr_rvalid_o && !data_rvalid_o && (instr_req_i || data_req_i)) begin
          state_d   = ISSUE;
          mem_req_d = 1'b1;
          if (grant_instr) begin
            owner_d     = OWN_INSTR;
            mem_we_d    = 1'b0;
            mem_be_d    = '1;
            mem_addr_d  = instr_addr_i;
            mem_wdata_d = '0;
            starve_d    = '0;
          end else begin
            owner_d     = OWN_DATA;
            mem_we_d    = data_we_i;
            mem_be_d    = data_be_i;
            mem_addr_d  = data_addr_i;
            mem_wdata_d = data_wdata_i;
            starve_d    = instr_req_i ? starve_inc(starve_q) : '0;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
          if (owner_q == OWN_INSTR) begin
            instr_rvalid_d = 1'b1;
            instr_rdata_d  = mem_rdata_i;
          end else begin
            data_rvalid_d = 1'b1;
            data_rdata_d  = mem_rdata_i;
          end
        end else if (wd_expire) begin
          // Abandon the transaction; the owner still holds req and is re-arbitrated.
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_q        <= IDLE;
      owner_q        <= OWN_INSTR;
      starve_q       <= '0;
      mem_req_o      <= 1'b0;
      mem_we_o       <= 1'b0;
      mem_be_o       <= '0;
      mem_addr_o     <= '0;
      mem_wdata_o    <= '0;
      instr_rvalid_o <= 1'b0;
      data_rvalid_o  <= 1'b0;
      instr_rdata_o  <= '0;
      data_rdata_o   <= '0;
      timeout_o      <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      starve_q       <= starve_d;
      mem_req_o      <= mem_req_d;
      mem_we_o       <= mem_we_d;
      mem_be_o       <= mem_be_d;
      mem_addr_o     <= mem_addr_d;
      mem_wdata_o    <= mem_wdata_d;
      instr_rvalid_o <= instr_rvalid_d;
      data_rvalid_o  <= data_rvalid_d;
      instr_rdata_o  <= instr_rdata_d;
      data_rdata_o   <= data_rdata_d;
      timeout_o      <= timeout_d;
      busy_o         <= busy_d;
    end
  end

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Directed bench for miriscv_mem_arbiter: a small memory model answers each
// mem_req_o pulse after a programmable latency, and every issued address is
// logged so the grant order can be checked.
module tb_miriscv_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W = DATA_W / 8;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT_CYC = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              arstn;
  logic              instr_req;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_rvalid_o;
  logic [DATA_W-1:0] instr_rdata_o;
  logic              data_req, data_we;
  logic [BE_W-1:0]   data_be;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_rvalid_o;
  logic [DATA_W-1:0] data_rdata_o;
  logic              mem_req_o, mem_we_o;
  logic [BE_W-1:0]   mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              timeout_o, busy_o;

  int vectors = 0;
  int miscompares = 0;

  // Memory model: response appears `lat` cycles after mem_req_o is visible.
  logic              mem_en = 1'b0;
  int                lat = 2;
  logic [DATA_W-1:0] resp_data = '0;
  logic              model_rvalid = 1'b0;
  logic [DATA_W-1:0] model_rdata = '0;
  logic              spur_rvalid = 1'b0;
  logic              pend = 1'b0;
  int                cnt = 0;
  logic [ADDR_W-1:0] grant_q[$];

  assign mem_rvalid_i = model_rvalid | spur_rvalid;
  assign mem_rdata_i  = spur_rvalid ? 32'hBAD0_BAD0 : model_rdata;

  always @(posedge clk) begin
    model_rvalid <= 1'b0;
    if (pend) begin
      if (cnt <= 1) begin
        model_rvalid <= 1'b1;
        model_rdata  <= resp_data;
        pend         <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end else if (mem_en && mem_req_o === 1'b1) begin
      pend <= 1'b1;
      cnt  <= lat - 1;
    end
  end

  always @(posedge clk) begin
    if (mem_req_o === 1'b1) grant_q.push_back(mem_addr_o);
  end

  miriscv_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_i(clk), .arstn_i(arstn),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .timeout_o(timeout_o), .busy_o(busy_o)
  );

  task automatic wait_rvalid(input bit is_data, input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      seen = is_data ? (data_rvalid_o === 1'b1) : (instr_rvalid_o === 1'b1);
    end
  endtask

  task automatic test_reset;
    bit seen;
    arstn = 1'b0; mem_en = 1'b1; lat = 2; resp_data = 32'h1111_2222;
    instr_req = 1'b1; instr_addr = 32'h80;
    data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h3000; data_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== '0) begin miscompares++;
      $display("FAIL reset_mem: got req=%b we=%b be=%h addr=%h wdata=%h want all 0", mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o); end
    vectors++; if ({instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o} !== '0) begin miscompares++;
      $display("FAIL reset_resp: got irv=%b drv=%b ird=%h drd=%h want all 0", instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o); end
    vectors++; if ({timeout_o, busy_o} !== 2'b00) begin miscompares++;
      $display("FAIL reset_flags: got timeout=%b busy=%b want 0 0", timeout_o, busy_o); end
    arstn = 1'b1;
    @(negedge clk);
    vectors++; if ({mem_req_o, mem_addr_o, busy_o} !== {1'b1, 32'h3000, 1'b1}) begin miscompares++;
      $display("FAIL reset_first_grant: got req=%b addr=%h busy=%b want 1 00003000 1", mem_req_o, mem_addr_o, busy_o); end
    wait_rvalid(1'b1, 10, seen);
    vectors++; if ({seen, data_rdata_o} !== {1'b1, 32'h1111_2222}) begin miscompares++;
      $display("FAIL reset_data_resp: got seen=%b rdata=%h want 1 11112222", seen, data_rdata_o); end
    data_req = 1'b0; resp_data = 32'h3333_4444;
    wait_rvalid(1'b0, 10, seen);
    vectors++; if ({seen, instr_rdata_o} !== {1'b1, 32'h3333_4444}) begin miscompares++;
      $display("FAIL reset_instr_resp: got seen=%b rdata=%h want 1 33334444", seen, instr_rdata_o); end
    instr_req = 1'b0;
  endtask

  task automatic test_fetch;
    repeat (2) @(negedge clk);
    resp_data = 32'h13; lat = 2; instr_addr = 32'h80; instr_req = 1'b1;
    @(negedge clk);
    vectors++; if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h80}) begin miscompares++;
      $display("FAIL fetch_issue: got req=%b we=%b be=%h addr=%h want 1 0 f 00000080", mem_req_o, mem_we_o, mem_be_o, mem_addr_o); end
    @(negedge clk);
    vectors++; if ({mem_req_o, busy_o} !== 2'b01) begin miscompares++;
      $display("FAIL fetch_wait: got req=%b busy=%b want 0 1", mem_req_o, busy_o); end
    @(negedge clk);
    vectors++; if (instr_rvalid_o !== 1'b0) begin miscompares++;
      $display("FAIL fetch_rvalid_early: got %b want 0", instr_rvalid_o); end
    @(negedge clk);
    vectors++; if ({instr_rvalid_o, instr_rdata_o, data_rvalid_o, data_rdata_o} !== {1'b1, 32'h13, 1'b0, 32'h1111_2222}) begin miscompares++;
      $display("FAIL fetch_resp: got irv=%b ird=%h drv=%b drd=%h want 1 00000013 0 11112222", instr_rvalid_o, instr_rdata_o, data_rvalid_o, data_rdata_o); end
    instr_req = 1'b0;
    @(negedge clk);
    vectors++; if ({instr_rvalid_o, busy_o} !== 2'b00) begin miscompares++;
      $display("FAIL fetch_done: got irv=%b busy=%b want 0 0", instr_rvalid_o, busy_o); end
  endtask

  task automatic test_store_vs_fetch;
    bit seen;
    repeat (2) @(negedge clk);
    resp_data = 32'h0; lat = 2;
    data_req = 1'b1; data_we = 1'b1; data_be = 4'h3; data_addr = 32'h1000; data_wdata = 32'hDEAD_BEEF;
    instr_req = 1'b1; instr_addr = 32'h84;
    @(negedge clk);
    vectors++; if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b1, 4'h3, 32'h1000, 32'hDEAD_BEEF}) begin miscompares++;
      $display("FAIL store_issue: got req=%b we=%b be=%h addr=%h wdata=%h want 1 1 3 00001000 deadbeef", mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o); end
    wait_rvalid(1'b1, 10, seen);
    vectors++; if ({seen, instr_rvalid_o} !== 2'b10) begin miscompares++;
      $display("FAIL store_resp: got seen=%b irv=%b want 1 0", seen, instr_rvalid_o); end
    data_req = 1'b0; data_we = 1'b0; resp_data = 32'h93;
    @(negedge clk);
    vectors++; if (mem_req_o !== 1'b0) begin miscompares++;
      $display("FAIL store_stall: got req=%b want 0", mem_req_o); end
    @(negedge clk);
    vectors++; if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h84}) begin miscompares++;
      $display("FAIL store_then_fetch: got req=%b we=%b be=%h addr=%h want 1 0 f 00000084", mem_req_o, mem_we_o, mem_be_o, mem_addr_o); end
    wait_rvalid(1'b0, 10, seen);
    vectors++; if ({seen, instr_rdata_o} !== {1'b1, 32'h93}) begin miscompares++;
      $display("FAIL store_fetch_resp: got seen=%b rdata=%h want 1 00000093", seen, instr_rdata_o); end
    instr_req = 1'b0;
  endtask

  task automatic test_starvation;
    int guard;
    logic [ADDR_W-1:0] got, exp;
    repeat (2) @(negedge clk);
    grant_q.delete();
    lat = 2; instr_addr = 32'h80;
    data_addr = 32'h2000; data_we = 1'b0; data_be = 4'hF;
    instr_req = 1'b1; data_req = 1'b1;
    guard = 0;
    while (grant_q.size() < 10 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    instr_req = 1'b0; data_req = 1'b0;
    vectors++; if (grant_q.size() < 10) begin miscompares++;
      $display("FAIL starve_count: got %0d grants want at least 10", grant_q.size()); end
    for (int i = 0; i < 10; i++) begin
      exp = (i % 5 == 4) ? 32'h80 : 32'h2000;
      got = (i < grant_q.size()) ? grant_q[i] : 'x;
      vectors++; if (got !== exp) begin miscompares++;
        $display("FAIL starve_grant%0d: got addr %h want %h", i, got, exp); end
    end
    repeat (12) @(negedge clk);
    vectors++; if (busy_o !== 1'b0) begin miscompares++;
      $display("FAIL starve_drain: got busy=%b want 0", busy_o); end
  endtask

  task automatic test_timeout;
    bit seen;
    bit rv_seen;
    repeat (2) @(negedge clk);
    mem_en = 1'b0; instr_addr = 32'h88; instr_req = 1'b1;
    rv_seen = 1'b0;
    repeat (17) begin
      @(negedge clk);
      rv_seen |= (instr_rvalid_o !== 1'b0);
    end
    vectors++; if (timeout_o !== 1'b0) begin miscompares++;
      $display("FAIL timeout_early: got %b want 0", timeout_o); end
    @(negedge clk);
    rv_seen |= (instr_rvalid_o !== 1'b0);
    vectors++; if ({timeout_o, busy_o} !== 2'b10) begin miscompares++;
      $display("FAIL timeout_set: got timeout=%b busy=%b want 1 0", timeout_o, busy_o); end
    vectors++; if (rv_seen !== 1'b0) begin miscompares++;
      $display("FAIL timeout_no_rvalid: got %b want 0", rv_seen); end
    mem_en = 1'b1; resp_data = 32'h17; lat = 2;
    @(negedge clk);
    vectors++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h88}) begin miscompares++;
      $display("FAIL timeout_reissue: got req=%b addr=%h want 1 00000088", mem_req_o, mem_addr_o); end
    wait_rvalid(1'b0, 10, seen);
    vectors++; if ({seen, instr_rdata_o, timeout_o} !== {1'b1, 32'h17, 1'b1}) begin miscompares++;
      $display("FAIL timeout_sticky: got seen=%b rdata=%h timeout=%b want 1 00000017 1", seen, instr_rdata_o, timeout_o); end
    instr_req = 1'b0;
  endtask

  task automatic test_spurious_and_reset;
    bit seen;
    bit rv_seen;
    repeat (2) @(negedge clk);
    arstn = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if ({timeout_o, instr_rdata_o, data_rdata_o} !== '0) begin miscompares++;
      $display("FAIL rst_clear: got timeout=%b ird=%h drd=%h want 0 0 0", timeout_o, instr_rdata_o, data_rdata_o); end
    arstn = 1'b1;
    @(negedge clk);
    spur_rvalid = 1'b1;
    @(negedge clk);
    spur_rvalid = 1'b0;
    rv_seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      rv_seen |= (instr_rvalid_o !== 1'b0) || (data_rvalid_o !== 1'b0) || (busy_o !== 1'b0);
    end
    vectors++; if ({rv_seen, instr_rdata_o, data_rdata_o} !== '0) begin miscompares++;
      $display("FAIL spurious: got activity=%b ird=%h drd=%h want 0 0 0", rv_seen, instr_rdata_o, data_rdata_o); end
    lat = 4; resp_data = 32'h5555_AAAA;
    data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h4000;
    @(negedge clk);
    vectors++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h4000}) begin miscompares++;
      $display("FAIL abort_issue: got req=%b addr=%h want 1 00004000", mem_req_o, mem_addr_o); end
    @(negedge clk);
    arstn = 1'b0; data_req = 1'b0;
    @(negedge clk);
    vectors++; if (busy_o !== 1'b0) begin miscompares++;
      $display("FAIL abort_idle: got busy=%b want 0", busy_o); end
    arstn = 1'b1;
    rv_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      rv_seen |= (instr_rvalid_o !== 1'b0) || (data_rvalid_o !== 1'b0) || (busy_o !== 1'b0);
    end
    vectors++; if ({rv_seen, data_rdata_o} !== '0) begin miscompares++;
      $display("FAIL late_rvalid: got activity=%b drd=%h want 0 0", rv_seen, data_rdata_o); end
    lat = 2; resp_data = 32'hCAFE_F00D; data_addr = 32'h4004; data_req = 1'b1;
    wait_rvalid(1'b1, 10, seen);
    vectors++; if ({seen, data_rdata_o} !== {1'b1, 32'hCAFE_F00D}) begin miscompares++;
      $display("FAIL after_abort: got seen=%b rdata=%h want 1 cafef00d", seen, data_rdata_o); end
    data_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_vs_fetch();
    test_starvation();
    test_timeout();
    test_spurious_and_reset();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
